// File: rtl/cell_assembler_if.sv
// Shared image-processing types and the cell_assembler handshake bundle.
// The package holds the instruction format consumed by the ALU stage; the
// interface groups the command, pixel and instruction handshakes.

package ImageProcessingPkg;
  localparam int CellSize = 2;

  typedef enum logic [3:0] {
    ADD   = 4'd0,
    ADDI  = 4'd1,
    SUB   = 4'd2,
    SUBI  = 4'd3,
    MULT  = 4'd4,
    MULTI = 4'd5,
    DIV2  = 4'd6,
    INV   = 4'd7,
    AND   = 4'd8,
    OR    = 4'd9,
    NOR   = 4'd10
  } opcodes_t;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } pixel_t;

  typedef struct packed {
    pixel_t [CellSize:0][CellSize:0] pixelMatrix;
  } pixelMatrix_t;

  typedef struct packed {
    opcodes_t     opcode;
    logic [7:0]   userInputA;
    pixelMatrix_t cellA;
    pixelMatrix_t cellB;
  } instruction_t;
endpackage

interface cell_assembler_if #(
  parameter int PIX_W = 24
);
  logic                            cmd_valid;
  logic                            cmd_ready;
  logic [3:0]                      cmd_op;
  logic [7:0]                      cmd_user;
  logic                            pix_valid;
  logic                            pix_ready;
  logic [PIX_W-1:0]                pix_data;
  logic                            out_valid;
  logic                            out_ready;
  ImageProcessingPkg::instruction_t out_instr;
  logic                            busy;
  logic                            err_op;

  // Environment side: command/pixel source and instruction consumer.
  modport master (
    output cmd_valid, cmd_op, cmd_user, pix_valid, pix_data, out_ready,
    input  cmd_ready, pix_ready, out_valid, out_instr, busy, err_op
  );

  // Assembler side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_user, pix_valid, pix_data, out_ready,
    output cmd_ready, pix_ready, out_valid, out_instr, busy, err_op
  );
endinterface

// File: rtl/cell_assembler.sv
// cell_assembler: accepts one command, then packs a raster-ordered pixel
// stream into cellA (and cellB for two-operand opcodes) and presents the
// assembled instruction on a valid/ready output.
// Optional feature macro: OPCODE_CHECK_EN (reject opcodes above NOR with a
// sticky err_op flag instead of treating them as two-operand commands).

module cell_assembler #(
  parameter int CELL_DIM = 3,
  parameter int PIX_W    = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  cell_assembler_if.slave bus
);
  import ImageProcessingPkg::*;

  localparam int                IDX_W    = (CELL_DIM > 1) ? $clog2(CELL_DIM) : 1;
  localparam logic [3:0]        LAST_PIX = 4'(CELL_DIM * CELL_DIM - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CELL_DIM - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    OUT
  } state_t;

  state_t           state;
  logic [3:0]       pixCnt;
  logic [IDX_W-1:0] rowIdx;
  logic [IDX_W-1:0] colIdx;
  instruction_t     instr;
  logic             cmdReady;
  logic             pixReady;
  logic             outValid;
  logic             busyReg;
  logic [PIX_W-1:0] pixIn;
  logic             pixFire;
  logic             lastPix;
`ifdef OPCODE_CHECK_EN
  logic             errOp;
`endif

  // Opcodes that carry only one cell operand; cellB stays zero for them.
  function automatic logic isUnary(input logic [3:0] op);
    case (op)
      4'(ADDI), 4'(SUBI), 4'(MULTI), 4'(DIV2), 4'(INV): isUnary = 1'b1;
      default:                                          isUnary = 1'b0;
    endcase
  endfunction

  assign pixIn   = bus.pix_data;
  assign pixFire = bus.pix_valid && pixReady;
  assign lastPix = (pixCnt == LAST_PIX);

  // Control FSM, pixel counters and instruction register; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pixCnt   <= '0;
      rowIdx   <= '0;
      colIdx   <= '0;
      instr    <= '0;
      cmdReady <= 1'b1;
      pixReady <= 1'b0;
      outValid <= 1'b0;
      busyReg  <= 1'b0;
`ifdef OPCODE_CHECK_EN
      errOp    <= 1'b0;
`endif
    end else begin
      // Raster position advances only on an accepted pixel; wraps per cell.
      if (pixFire) begin
        if (lastPix) begin
          pixCnt <= '0;
          rowIdx <= '0;
          colIdx <= '0;
        end else begin
          pixCnt <= pixCnt + 4'd1;
          if (colIdx == LAST_IDX) begin
            colIdx <= '0;
            rowIdx <= rowIdx + 1'b1;
          end else begin
            colIdx <= colIdx + 1'b1;
          end
        end
      end

      case (state)
        IDLE: begin
          if (bus.cmd_valid && cmdReady) begin
`ifdef OPCODE_CHECK_EN
            if (bus.cmd_op > 4'(NOR)) begin
              // Illegal opcode: flag it, stay ready, consume no pixels.
              errOp <= 1'b1;
            end else
`endif
            begin
              instr.opcode     <= opcodes_t'(bus.cmd_op);
              instr.userInputA <= bus.cmd_user;
              instr.cellA      <= '0;
              instr.cellB      <= '0;
              state            <= LOAD_A;
              cmdReady         <= 1'b0;
              pixReady         <= 1'b1;
              busyReg          <= 1'b1;
            end
          end
        end

        LOAD_A: begin
          if (pixFire) begin
            instr.cellA.pixelMatrix[rowIdx][colIdx] <= pixel_t'(pixIn);
            if (lastPix) begin
              if (isUnary(4'(instr.opcode))) begin
                state    <= OUT;
                pixReady <= 1'b0;
                outValid <= 1'b1;
              end else begin
                state <= LOAD_B;
              end
            end
          end
        end

        LOAD_B: begin
          if (pixFire) begin
            instr.cellB.pixelMatrix[rowIdx][colIdx] <= pixel_t'(pixIn);
            if (lastPix) begin
              state    <= OUT;
              pixReady <= 1'b0;
              outValid <= 1'b1;
            end
          end
        end

        OUT: begin
          if (outValid && bus.out_ready) begin
            state    <= IDLE;
            outValid <= 1'b0;
            cmdReady <= 1'b1;
            busyReg  <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          cmdReady <= 1'b1;
          pixReady <= 1'b0;
          outValid <= 1'b0;
          busyReg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmdReady;
  assign bus.pix_ready = pixReady;
  assign bus.out_valid = outValid;
  assign bus.out_instr = instr;
  assign bus.busy      = busyReg;
`ifdef OPCODE_CHECK_EN
  assign bus.err_op    = errOp;
`else
  assign bus.err_op    = 1'b0;
`endif

endmodule

// File: tb/tb_cell_assembler.sv
// Directed testbench for cell_assembler: reset values, two-operand and
// one-operand assembly, output back-pressure, pixel gaps, mid-operation
// reset and out-of-range opcodes.

module tb_cell_assembler;
  import ImageProcessingPkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  cell_assembler_if #(.PIX_W(24)) ifc();

  cell_assembler #(.CELL_DIM(3), .PIX_W(24)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, want finish before 200000ns");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sendCmd(input logic [3:0] op, input logic [7:0] user);
    int n = 0;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = op;
    ifc.cmd_user  = user;
    while (!ifc.cmd_ready && n < 50) begin
      step();
      n++;
    end
    if (!ifc.cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_timeout cmd_ready=%0b want 1", ifc.cmd_ready);
    end
    step();
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic sendPix(input logic [23:0] p, input bit gaps);
    int n = 0;
    if (gaps && $urandom_range(0, 1) == 1) begin
      ifc.pix_valid = 1'b0;
      step();
    end
    ifc.pix_valid = 1'b1;
    ifc.pix_data  = p;
    while (!ifc.pix_ready && n < 50) begin
      step();
      n++;
    end
    if (!ifc.pix_ready) begin
      checks++;
      errors++;
      $display("FAIL pix_timeout pix_ready=%0b want 1", ifc.pix_ready);
    end
    step();
    ifc.pix_valid = 1'b0;
  endtask

  task automatic sendCell(input logic [23:0] base, input logic [23:0] inc, input bit gaps);
    for (int k = 0; k < 9; k++) sendPix(base + 24'(k) * inc, gaps);
  endtask

  task automatic handshake();
    ifc.out_ready = 1'b1;
    step();
    ifc.out_ready = 1'b0;
  endtask

  function automatic instruction_t mkInstr(input logic [3:0] op, input logic [7:0] user,
                                           input logic [23:0] aBase, input logic [23:0] aInc,
                                           input bit hasB,
                                           input logic [23:0] bBase, input logic [23:0] bInc);
    instruction_t e;
    e = '0;
    e.opcode     = opcodes_t'(op);
    e.userInputA = user;
    for (int k = 0; k < 9; k++) begin
      e.cellA.pixelMatrix[k / 3][k % 3] = pixel_t'(aBase + 24'(k) * aInc);
      if (hasB) e.cellB.pixelMatrix[k / 3][k % 3] = pixel_t'(bBase + 24'(k) * bInc);
    end
    return e;
  endfunction

  task automatic test_reset();
    if (ifc.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %0b want 1", ifc.cmd_ready); end
    checks++;
    if (ifc.pix_ready !== 1'b0) begin errors++; $display("FAIL rst_pix_ready got %0b want 0", ifc.pix_ready); end
    checks++;
    if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b want 0", ifc.out_valid); end
    checks++;
    if (ifc.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", ifc.busy); end
    checks++;
    if (ifc.err_op !== 1'b0) begin errors++; $display("FAIL rst_err_op got %0b want 0", ifc.err_op); end
    checks++;
    if (ifc.out_instr !== '0) begin errors++; $display("FAIL rst_out_instr got %h want 0", ifc.out_instr); end
    checks++;
  endtask

  task automatic test_add();
    instruction_t exp;
    exp = mkInstr(4'd0, 8'h00, 24'h010203, 24'h000001, 1'b1, 24'h0A0B0C, 24'h000000);
    sendCmd(4'd0, 8'h00);
    if (ifc.busy !== 1'b1 || ifc.cmd_ready !== 1'b0 || ifc.pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_accept busy/cmd_ready/pix_ready got %0b%0b%0b want 101",
               ifc.busy, ifc.cmd_ready, ifc.pix_ready);
    end
    checks++;
    sendCell(24'h010203, 24'h000001, 1'b0);
    for (int k = 0; k < 8; k++) sendPix(24'h0A0B0C, 1'b0);
    if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid got %0b want 0", ifc.out_valid); end
    checks++;
    sendPix(24'h0A0B0C, 1'b0);
    if (ifc.out_valid !== 1'b1 || ifc.pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL add_out_valid out_valid/pix_ready got %0b%0b want 10", ifc.out_valid, ifc.pix_ready);
    end
    checks++;
    if (ifc.out_instr.cellA.pixelMatrix[1][2] !== 24'h010208) begin
      errors++;
      $display("FAIL add_cellA_1_2 got %h want 010208", ifc.out_instr.cellA.pixelMatrix[1][2]);
    end
    checks++;
    if (ifc.out_instr !== exp) begin errors++; $display("FAIL add_instr got %h want %h", ifc.out_instr, exp); end
    checks++;
    handshake();
    if (ifc.out_valid !== 1'b0 || ifc.cmd_ready !== 1'b1 || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL add_release out_valid/cmd_ready/busy got %0b%0b%0b want 010",
               ifc.out_valid, ifc.cmd_ready, ifc.busy);
    end
    checks++;
  endtask

  task automatic test_addi_hold();
    instruction_t exp;
    exp = mkInstr(4'd1, 8'h05, 24'h100000, 24'h000101, 1'b0, 24'h0, 24'h0);
    sendCmd(4'd1, 8'h05);
    sendCell(24'h100000, 24'h000101, 1'b0);
    if (ifc.out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %0b want 1", ifc.out_valid); end
    checks++;
    if (ifc.out_instr.cellB !== '0 || ifc.out_instr.userInputA !== 8'h05) begin
      errors++;
      $display("FAIL addi_fields cellB=%h user=%h want 0 and 05", ifc.out_instr.cellB, ifc.out_instr.userInputA);
    end
    checks++;
    if (ifc.out_instr !== exp) begin errors++; $display("FAIL addi_instr got %h want %h", ifc.out_instr, exp); end
    checks++;
    // A 10th pixel and a new command are both offered while the output is held.
    ifc.pix_valid = 1'b1;
    ifc.pix_data  = 24'hFFFFFF;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = 4'd4;
    ifc.cmd_user  = 8'h99;
    for (int c = 0; c < 7; c++) begin
      step();
      if (ifc.out_valid !== 1'b1 || ifc.out_instr !== exp || ifc.pix_ready !== 1'b0 || ifc.cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d out_valid=%0b pix_ready=%0b cmd_ready=%0b instr=%h want 1 0 0 %h",
                 c, ifc.out_valid, ifc.pix_ready, ifc.cmd_ready, ifc.out_instr, exp);
      end
      checks++;
    end
    ifc.pix_valid = 1'b0;
    ifc.cmd_valid = 1'b0;
    handshake();
    if (ifc.out_valid !== 1'b0 || ifc.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release out_valid/cmd_ready got %0b%0b want 01", ifc.out_valid, ifc.cmd_ready);
    end
    checks++;
  endtask

  task automatic test_gaps();
    instruction_t exp;
    instruction_t ref0;
    exp = mkInstr(4'd2, 8'h3C, 24'h203040, 24'h010101, 1'b1, 24'hF0E0D0, 24'hFF0001);
    sendCmd(4'd2, 8'h3C);
    sendCell(24'h203040, 24'h010101, 1'b0);
    sendCell(24'hF0E0D0, 24'hFF0001, 1'b0);
    ref0 = ifc.out_instr;
    if (ifc.out_valid !== 1'b1 || ref0 !== exp) begin
      errors++;
      $display("FAIL sub_nogap valid=%0b got %h want %h", ifc.out_valid, ref0, exp);
    end
    checks++;
    handshake();
    sendCmd(4'd2, 8'h3C);
    sendCell(24'h203040, 24'h010101, 1'b1);
    sendCell(24'hF0E0D0, 24'hFF0001, 1'b1);
    if (ifc.out_valid !== 1'b1 || ifc.out_instr !== exp) begin
      errors++;
      $display("FAIL sub_gaps valid=%0b got %h want %h", ifc.out_valid, ifc.out_instr, exp);
    end
    checks++;
    if (ifc.out_instr !== ref0) begin errors++; $display("FAIL sub_gap_vs_nogap got %h want %h", ifc.out_instr, ref0); end
    checks++;
    handshake();
  endtask

  task automatic test_reset_mid();
    instruction_t exp;
    sendCmd(4'd4, 8'h11);
    sendCell(24'h0F0F0F, 24'h000010, 1'b0);
    for (int k = 0; k < 5; k++) sendPix(24'h555555, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    if (ifc.busy !== 1'b0 || ifc.pix_ready !== 1'b0 || ifc.cmd_ready !== 1'b1 ||
        ifc.out_valid !== 1'b0 || ifc.out_instr !== '0) begin
      errors++;
      $display("FAIL midrst busy=%0b pix_ready=%0b cmd_ready=%0b out_valid=%0b instr=%h want 0 0 1 0 0",
               ifc.busy, ifc.pix_ready, ifc.cmd_ready, ifc.out_valid, ifc.out_instr);
    end
    checks++;
    rst_n = 1'b1;
    step();
    exp = mkInstr(4'd4, 8'h22, 24'h000001, 24'h000002, 1'b1, 24'h808080, 24'h010000);
    sendCmd(4'd4, 8'h22);
    sendCell(24'h000001, 24'h000002, 1'b0);
    sendCell(24'h808080, 24'h010000, 1'b0);
    if (ifc.out_valid !== 1'b1 || ifc.out_instr !== exp) begin
      errors++;
      $display("FAIL mult_after_rst valid=%0b got %h want %h", ifc.out_valid, ifc.out_instr, exp);
    end
    checks++;
    handshake();
  endtask

  task automatic test_badop();
`ifdef OPCODE_CHECK_EN
    ifc.pix_valid = 1'b1;
    ifc.pix_data  = 24'h123456;
    sendCmd(4'd13, 8'h77);
    if (ifc.err_op !== 1'b1 || ifc.cmd_ready !== 1'b1 || ifc.busy !== 1'b0 ||
        ifc.out_valid !== 1'b0 || ifc.pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL badop err_op=%0b cmd_ready=%0b busy=%0b out_valid=%0b pix_ready=%0b want 1 1 0 0 0",
               ifc.err_op, ifc.cmd_ready, ifc.busy, ifc.out_valid, ifc.pix_ready);
    end
    checks++;
    step();
    step();
    if (ifc.err_op !== 1'b1 || ifc.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL badop_sticky err_op=%0b out_valid=%0b want 1 0", ifc.err_op, ifc.out_valid);
    end
    checks++;
    ifc.pix_valid = 1'b0;
`else
    instruction_t exp;
    exp = mkInstr(4'd13, 8'h77, 24'hABCDEF, 24'h000003, 1'b1, 24'h000100, 24'h000100);
    sendCmd(4'd13, 8'h77);
    if (ifc.err_op !== 1'b0 || ifc.busy !== 1'b1) begin
      errors++;
      $display("FAIL op13_accept err_op=%0b busy=%0b want 0 1", ifc.err_op, ifc.busy);
    end
    checks++;
    sendCell(24'hABCDEF, 24'h000003, 1'b0);
    if (ifc.out_valid !== 1'b0 || ifc.pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL op13_binary out_valid=%0b pix_ready=%0b want 0 1", ifc.out_valid, ifc.pix_ready);
    end
    checks++;
    sendCell(24'h000100, 24'h000100, 1'b0);
    if (ifc.out_valid !== 1'b1 || 4'(ifc.out_instr.opcode) !== 4'd13 || ifc.out_instr !== exp) begin
      errors++;
      $display("FAIL op13_instr valid=%0b got %h want %h", ifc.out_valid, ifc.out_instr, exp);
    end
    checks++;
    handshake();
`endif
  endtask

  initial begin
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = 4'd0;
    ifc.cmd_user  = 8'h00;
    ifc.pix_valid = 1'b0;
    ifc.pix_data  = 24'h0;
    ifc.out_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    test_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    test_add();
    test_addi_hold();
    test_gaps();
    test_reset_mid();
    test_badop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
